player_ctrl_n: RTL and testbench
================================

Name: player_ctrl_n

Overview:
- Parametrised successor to the single-shot player controller.
- Handles horizontal player movement and a pool of N_SHOTS independent player projectiles.
- Checks hits against N_EPROJ enemy-projectile channels, tracks lives, and applies a post-hit invulnerability window.
- Runs a game-state FSM: IDLE, ALIVE, HIT, OVER. Sits between keypad/button decode and the enemy and VGA render blocks.

Parameters:
- N_SHOTS, 4: player projectile slots.
- N_EPROJ, 11: enemy projectile channels checked for hits.
- CW, 10: coordinate width.
- LW, 3: lives counter width.
- X_MIN, 90: left clamp for player_x.
- X_MAX, 550: right clamp for player_x.
- START_X, 320: player_x at start.
- START_Y, 420: fixed player_y.
- PARK_Y, 470: y value of an inactive shot.
- SHOT_SPEED, 2: shot y decrement per cycle.
- LIVES_INIT, 5: lives at game start.
- INVULN, 32: cycles of invulnerability after a hit.
- COOLDOWN, 8: minimum cycles between fires.
- HIT_DX, 15: horizontal hit half-window.
- HIT_DY, 20: vertical hit window above player_y.

Ports:
- clk_4  in  1  game tick clock.
- clr_n  in  1  asynchronous active-low reset.
- play  in  1  level; 0 forces IDLE.
- left  in  1  move left request.
- right  in  1  move right request.
- shoot  in  1  fire request, level-sensitive.
- shot_hit  in  N_SHOTS  per-slot "shot struck enemy" from enemy blocks.
- eproj_x  in  N_EPROJ*CW  packed enemy projectile x; channel i at [i*CW +: CW].
- eproj_y  in  N_EPROJ*CW  packed enemy projectile y.
- eproj_valid  in  N_EPROJ  channel holds a live projectile.
- player_x  out  CW
- player_y  out  CW  constant START_Y.
- shots_x  out  N_SHOTS*CW  packed.
- shots_y  out  N_SHOTS*CW  packed.
- shots_active  out  N_SHOTS
- hit_ack  out  N_EPROJ  one-cycle pulse: retire that enemy projectile.
- lives  out  LW
- invuln  out  1  high in HIT state.
- gameover  out  1
- state  out  2  IDLE=0, ALIVE=1, HIT=2, OVER=3.

Behaviour:

Reset (clr_n=0, async), and every cycle in IDLE:
- state=IDLE, player_x=START_X, lives=LIVES_INIT.
- All shots inactive: x=0, y=PARK_Y.
- hit_ack=0, gameover=0, invuln=0, cooldown=0, invuln counter=0.

FSM, all registered on posedge clk_4:
- play=0 in any state → IDLE next cycle, outputs initialised. This has priority over everything below.
- IDLE, play=1 → ALIVE.
- ALIVE, any hit detected → HIT with lives-1. If lives was 1, go to OVER with lives=0 instead.
- HIT: counter runs INVULN cycles, then → ALIVE. Hit detection and hit_ack are suppressed in HIT.
- OVER: gameover=1, all shots parked, movement and fire ignored. Stay until play=0.

Movement (ALIVE and HIT only):
- left only and player_x>X_MIN: player_x decrements by 1.
- right only and player_x<X_MAX: player_x increments by 1.
- left and right together: no move.

Shots:
- Active shot: y -= SHOT_SPEED each cycle.
- A shot retires (inactive, x=0, y=PARK_Y) when y<SHOT_SPEED (no wrap) or when its shot_hit bit is 1. Retirement beats the move in the same cycle.
- Fire condition: shoot=1, cooldown=0, state ALIVE or HIT, and at least one slot inactive at the start of the cycle.
- On fire: the lowest-index inactive slot gets x=player_x (pre-move value), y=player_y, active=1. Cooldown loads COOLDOWN and decrements to 0.
- If no slot is free, the request is dropped and cooldown is not loaded.
- A slot retired this cycle cannot be refilled until the next cycle.

Hit detection (combinational on the registered player_x and inputs; results registered):
- Channel i hits when all hold: eproj_valid[i]; ey<player_y; player_y-ey<HIT_DY; ex+HIT_DX>player_x; ex<player_x+HIT_DX.
- Compute all sums at CW+1 bits so nothing wraps.
- In ALIVE, hit_ack[i] pulses for every hitting channel in that same cycle.
- Multiple simultaneous hits cost exactly one life.

Latency: one cycle from any input to the registered response.

Test Plan:
- Reset, then play=1 → state=1, player_x=320, lives=5, shots_active=0. Hold left 300 cycles → player_x settles at 90.
- Hold shoot for 40 cycles → fires at cycles 0, 8, 16, 24, filling slots 0..3. No fifth fire while all four are active. Slot 0 y=420,418,… and retires at y<2; slot 0 is refilled on the next eligible fire.
- Shot in slot 1 plus shot_hit[1]=1 while shoot=1 and the other slots are full → slot 1 parks at y=470, and no fire occurs that cycle.
- Channels 2 and 5 valid at (player_x+3, 410) in the same cycle → hit_ack=bits 2 and 5 for one cycle, lives 5→4, state=HIT for 32 cycles. A repeat hit during HIT gives no ack and no life loss.
- Force five separated hits → lives reaches 0, state=OVER, gameover=1, shots parked. play=0 → IDLE and lives=5.
- Assert clr_n=0 mid-HIT with shots active → immediate async return to IDLE values, with no waiting for a clock edge.

Source files
------------

// File: rtl/player_ctrl_n_if.sv
// rtl/player_ctrl_n_if.sv - player controller control/status bundle
interface player_ctrl_n_if #(
  parameter int N_SHOTS = 4,
  parameter int N_EPROJ = 11,
  parameter int CW      = 10,
  parameter int LW      = 3
) ();
  logic                    play;
  logic                    left;
  logic                    right;
  logic                    shoot;
  logic [N_SHOTS-1:0]      shot_hit;
  logic [N_EPROJ*CW-1:0]   eproj_x;
  logic [N_EPROJ*CW-1:0]   eproj_y;
  logic [N_EPROJ-1:0]      eproj_valid;
  logic [CW-1:0]           player_x;
  logic [CW-1:0]           player_y;
  logic [N_SHOTS*CW-1:0]   shots_x;
  logic [N_SHOTS*CW-1:0]   shots_y;
  logic [N_SHOTS-1:0]      shots_active;
  logic [N_EPROJ-1:0]      hit_ack;
  logic [LW-1:0]           lives;
  logic                    invuln;
  logic                    gameover;
  logic [1:0]              state;

  modport master (
    output play, left, right, shoot, shot_hit, eproj_x, eproj_y, eproj_valid,
    input  player_x, player_y, shots_x, shots_y, shots_active, hit_ack,
           lives, invuln, gameover, state
  );

  modport slave (
    input  play, left, right, shoot, shot_hit, eproj_x, eproj_y, eproj_valid,
    output player_x, player_y, shots_x, shots_y, shots_active, hit_ack,
           lives, invuln, gameover, state
  );
endinterface

// File: rtl/player_ctrl_n.sv
// rtl/player_ctrl_n.sv - player movement, multi-shot pool, hit/lives game FSM
module player_ctrl_n #(
  parameter int N_SHOTS    = 4,
  parameter int N_EPROJ    = 11,
  parameter int CW         = 10,
  parameter int LW         = 3,
  parameter int X_MIN      = 90,
  parameter int X_MAX      = 550,
  parameter int START_X    = 320,
  parameter int START_Y    = 420,
  parameter int PARK_Y     = 470,
  parameter int SHOT_SPEED = 2,
  parameter int LIVES_INIT = 5,
  parameter int INVULN     = 32,
  parameter int COOLDOWN   = 8,
  parameter int HIT_DX     = 15,
  parameter int HIT_DY     = 20
) (
  input  logic             clk_4,
  input  logic             clr_n,
  player_ctrl_n_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIVE = 2'd1,
    S_HIT   = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int CDW = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
  localparam int IVW = (INVULN > 1) ? $clog2(INVULN + 1) : 1;

  localparam logic [CW-1:0] L_X_MIN   = CW'(X_MIN);
  localparam logic [CW-1:0] L_X_MAX   = CW'(X_MAX);
  localparam logic [CW-1:0] L_START_X = CW'(START_X);
  localparam logic [CW-1:0] L_START_Y = CW'(START_Y);
  localparam logic [CW-1:0] L_PARK_Y  = CW'(PARK_Y);
  localparam logic [CW-1:0] L_SPEED   = CW'(SHOT_SPEED);
  localparam logic [CW:0]   L_DX      = (CW+1)'(HIT_DX);
  localparam logic [CW:0]   L_DY      = (CW+1)'(HIT_DY);
  localparam logic [LW-1:0] L_LIVES   = LW'(LIVES_INIT);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_player_x;
  logic [CW-1:0]        w_player_x_nxt;
  logic [LW-1:0]        r_lives;
  logic [CDW-1:0]       r_cool;
  logic [IVW-1:0]       r_inv;
  logic                 r_gameover;
  logic [N_EPROJ-1:0]   r_hit_ack;
  logic [N_EPROJ-1:0]   w_hit;
  logic                 w_any_hit;
  logic [CW-1:0]        r_sx [N_SHOTS];
  logic [CW-1:0]        r_sy [N_SHOTS];
  logic [CW-1:0]        w_sx_nxt [N_SHOTS];
  logic [CW-1:0]        w_sy_nxt [N_SHOTS];
  logic [N_SHOTS-1:0]   r_active;
  logic [N_SHOTS-1:0]   w_active_nxt;
  logic [N_SHOTS-1:0]   w_free;
  logic [N_SHOTS-1:0]   w_fire_oh;
  logic                 w_fire;
  logic                 w_playing;
  logic                 w_init;
  logic                 w_park;

  // One enemy projectile against the player box, widened by one bit so no sum wraps
  function automatic logic f_hit(input logic [CW-1:0] ex, input logic [CW-1:0] ey,
                                 input logic [CW-1:0] px);
    logic [CW:0] x;
    logic [CW:0] y;
    logic [CW:0] p;
    logic [CW:0] q;
    x = {1'b0, ex};
    y = {1'b0, ey};
    p = {1'b0, px};
    q = {1'b0, L_START_Y};
    return (y < q) && ((q - y) < L_DY) && ((x + L_DX) > p) && (x < (p + L_DX));
  endfunction

  assign w_playing = (r_state == S_ALIVE) || (r_state == S_HIT);
  assign w_init    = !bus.play || (r_state == S_IDLE);
  assign w_park    = (w_state_nxt == S_OVER);
  assign w_any_hit = |w_hit;

  // Per-channel hit detection on registered player_x and live inputs
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_EPROJ; i++) begin
      w_hit[i] = bus.eproj_valid[i] &&
                 f_hit(bus.eproj_x[i*CW +: CW], bus.eproj_y[i*CW +: CW], r_player_x);
    end
  end

  // Game-state next-state logic; play=0 overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (!bus.play) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_ALIVE;
        S_ALIVE: if (w_any_hit) w_state_nxt = (r_lives <= LW'(1)) ? S_OVER : S_HIT;
        S_HIT:   if (r_inv == '0) w_state_nxt = S_ALIVE;
        S_OVER:  w_state_nxt = S_OVER;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Horizontal movement with clamping; opposing requests cancel
  always_comb begin
    w_player_x_nxt = r_player_x;
    if (w_playing) begin
      if (bus.left && !bus.right && (r_player_x > L_X_MIN)) begin
        w_player_x_nxt = r_player_x - CW'(1);
      end else if (bus.right && !bus.left && (r_player_x < L_X_MAX)) begin
        w_player_x_nxt = r_player_x + CW'(1);
      end
    end
  end

  // Shot pool: retire/advance active slots, fill the lowest slot that was free at cycle start
  always_comb begin
    w_free    = ~r_active;
    w_fire    = bus.shoot && (r_cool == '0) && w_playing && (|w_free);
    w_fire_oh = w_fire ? (w_free & (~w_free + N_SHOTS'(1))) : '0;
    for (int i = 0; i < N_SHOTS; i++) begin
      w_sx_nxt[i]     = r_sx[i];
      w_sy_nxt[i]     = r_sy[i];
      w_active_nxt[i] = r_active[i];
      if (r_active[i]) begin
        if (bus.shot_hit[i] || (r_sy[i] < L_SPEED)) begin
          w_sx_nxt[i]     = '0;
          w_sy_nxt[i]     = L_PARK_Y;
          w_active_nxt[i] = 1'b0;
        end else begin
          w_sy_nxt[i] = r_sy[i] - L_SPEED;
        end
      end else if (w_fire_oh[i]) begin
        w_sx_nxt[i]     = r_player_x;
        w_sy_nxt[i]     = L_START_Y;
        w_active_nxt[i] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk_4 or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers; IDLE or play=0 holds everything at start-of-game values
  always_ff @(posedge clk_4 or negedge clr_n) begin
    if (!clr_n) begin
      r_player_x <= L_START_X;
      r_lives    <= L_LIVES;
      r_cool     <= '0;
      r_inv      <= '0;
      r_gameover <= 1'b0;
      r_hit_ack  <= '0;
      r_active   <= '0;
      for (int i = 0; i < N_SHOTS; i++) begin
        r_sx[i] <= '0;
        r_sy[i] <= L_PARK_Y;
      end
    end else if (w_init) begin
      r_player_x <= L_START_X;
      r_lives    <= L_LIVES;
      r_cool     <= '0;
      r_inv      <= '0;
      r_gameover <= 1'b0;
      r_hit_ack  <= '0;
      r_active   <= '0;
      for (int i = 0; i < N_SHOTS; i++) begin
        r_sx[i] <= '0;
        r_sy[i] <= L_PARK_Y;
      end
    end else begin
      r_player_x <= w_player_x_nxt;
      r_gameover <= (w_state_nxt == S_OVER);
      r_hit_ack  <= (r_state == S_ALIVE) ? w_hit : '0;

      if ((r_state == S_ALIVE) && w_any_hit) begin
        r_lives <= (r_lives <= LW'(1)) ? '0 : (r_lives - LW'(1));
      end

      if (w_state_nxt == S_HIT && r_state == S_ALIVE) begin
        r_inv <= IVW'(INVULN - 1);
      end else if (r_state == S_HIT && r_inv != '0) begin
        r_inv <= r_inv - IVW'(1);
      end

      if (w_park || r_state == S_OVER) begin
        r_cool   <= '0;
        r_active <= '0;
        for (int i = 0; i < N_SHOTS; i++) begin
          r_sx[i] <= '0;
          r_sy[i] <= L_PARK_Y;
        end
      end else begin
        // Reload with COOLDOWN-1 so consecutive fires land exactly COOLDOWN cycles apart
        if (w_fire) begin
          r_cool <= CDW'(COOLDOWN - 1);
        end else if (r_cool != '0) begin
          r_cool <= r_cool - CDW'(1);
        end
        r_active <= w_active_nxt;
        for (int i = 0; i < N_SHOTS; i++) begin
          r_sx[i] <= w_sx_nxt[i];
          r_sy[i] <= w_sy_nxt[i];
        end
      end
    end
  end

  // Pack shot registers onto the flat output buses
  always_comb begin
    bus.shots_x = '0;
    bus.shots_y = '0;
    for (int i = 0; i < N_SHOTS; i++) begin
      bus.shots_x[i*CW +: CW] = r_sx[i];
      bus.shots_y[i*CW +: CW] = r_sy[i];
    end
  end

  assign bus.player_x     = r_player_x;
  assign bus.player_y     = L_START_Y;
  assign bus.shots_active = r_active;
  assign bus.hit_ack      = r_hit_ack;
  assign bus.lives        = r_lives;
  assign bus.invuln       = (r_state == S_HIT);
  assign bus.gameover     = r_gameover;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_player_ctrl_n.sv
// tb/tb_player_ctrl_n.sv - scoreboard bench for player_ctrl_n
module tb_player_ctrl_n;
  localparam int CW = 10;

  localparam int F_STATE = 0;
  localparam int F_PX    = 1;
  localparam int F_LIVES = 2;
  localparam int F_SACT  = 3;
  localparam int F_SX    = 4;
  localparam int F_SY    = 5;
  localparam int F_INV   = 6;
  localparam int F_GO    = 7;
  localparam int F_PY    = 8;

  typedef struct {
    int cyc;
    int sel;
    int idx;
    int val;
  } exp_t;

  logic clk_4 = 1'b0;
  logic clr_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  logic [10:0] aq[$];

  player_ctrl_n_if bus ();

  player_ctrl_n dut (
    .clk_4 (clk_4),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk_4 = ~clk_4;
  always @(posedge clk_4) cyc <= cyc + 1;

  function automatic string sel_name(input int sel);
    case (sel)
      F_STATE: return "state";
      F_PX:    return "player_x";
      F_LIVES: return "lives";
      F_SACT:  return "shots_active";
      F_SX:    return "shots_x";
      F_SY:    return "shots_y";
      F_INV:   return "invuln";
      F_GO:    return "gameover";
      default: return "player_y";
    endcase
  endfunction

  function automatic int field(input int sel, input int idx);
    case (sel)
      F_STATE: return int'(bus.state);
      F_PX:    return int'(bus.player_x);
      F_LIVES: return int'(bus.lives);
      F_SACT:  return int'(bus.shots_active);
      F_SX:    return int'(bus.shots_x[idx*CW +: CW]);
      F_SY:    return int'(bus.shots_y[idx*CW +: CW]);
      F_INV:   return int'(bus.invuln);
      F_GO:    return int'(bus.gameover);
      default: return int'(bus.player_y);
    endcase
  endfunction

  // Monitor: retire due expectations each cycle and check every hit_ack pulse
  always @(negedge clk_4) begin
    exp_t e;
    int   act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_vec++;
      act = field(e.sel, e.idx);
      if (e.cyc < cyc) begin
        n_err++;
        $display("FAIL %s[%0d] not sampled at cycle %0d: got none required %0d",
                 sel_name(e.sel), e.idx, e.cyc, e.val);
      end else if (act != e.val) begin
        n_err++;
        $display("FAIL %s[%0d] cycle %0d: got %0d required %0d",
                 sel_name(e.sel), e.idx, cyc, act, e.val);
      end
    end
    if (bus.hit_ack !== 11'd0) begin
      n_vec++;
      if (aq.size() == 0) begin
        n_err++;
        $display("FAIL hit_ack cycle %0d: got %h required 000", cyc, bus.hit_ack);
      end else begin
        logic [10:0] ea;
        ea = aq.pop_front();
        if (bus.hit_ack !== ea) begin
          n_err++;
          $display("FAIL hit_ack cycle %0d: got %h required %h", cyc, bus.hit_ack, ea);
        end
      end
    end
  end

  task automatic chk(input int at, input int sel, input int idx, input int val);
    exp_t e;
    int   pos;
    e.cyc = at;
    e.sel = sel;
    e.idx = idx;
    e.val = val;
    pos = q.size();
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].cyc > at) begin
        pos = k;
        break;
      end
    end
    q.insert(pos, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_4);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic set_ep(input int ch, input int x, input int y);
    bus.eproj_x[ch*CW +: CW] = CW'(x);
    bus.eproj_y[ch*CW +: CW] = CW'(y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int s;
    int h;
    clr_n = 1'b0;
    bus.play = 1'b0;
    bus.left = 1'b0;
    bus.right = 1'b0;
    bus.shoot = 1'b0;
    bus.shot_hit = '0;
    bus.eproj_x = '0;
    bus.eproj_y = '0;
    bus.eproj_valid = '0;
    tick(2);

    // Reset state
    c = cyc;
    chk(c, F_STATE, 0, 0);
    chk(c, F_PX, 0, 320);
    chk(c, F_PY, 0, 420);
    chk(c, F_LIVES, 0, 5);
    chk(c, F_SACT, 0, 0);
    chk(c, F_SX, 0, 0);
    chk(c, F_SY, 0, 470);
    chk(c, F_GO, 0, 0);
    chk(c, F_INV, 0, 0);

    // Start game
    clr_n = 1'b1;
    bus.play = 1'b1;
    c = cyc;
    chk(c + 1, F_STATE, 0, 1);
    chk(c + 1, F_PX, 0, 320);
    chk(c + 1, F_LIVES, 0, 5);
    chk(c + 1, F_SACT, 0, 0);
    tick(1);

    // Walk left into the clamp
    bus.left = 1'b1;
    c = cyc;
    chk(c + 1, F_PX, 0, 319);
    chk(c + 229, F_PX, 0, 91);
    chk(c + 230, F_PX, 0, 90);
    chk(c + 231, F_PX, 0, 90);
    chk(c + 300, F_PX, 0, 90);
    tick(300);
    bus.right = 1'b1;
    chk(cyc + 1, F_PX, 0, 90);
    tick(1);
    bus.left = 1'b0;
    chk(cyc + 1, F_PX, 0, 91);
    tick(1);
    bus.left = 1'b1;
    bus.right = 1'b0;
    chk(cyc + 1, F_PX, 0, 90);
    tick(1);
    bus.left = 1'b0;

    // Fire with cooldown until the pool is full
    bus.shoot = 1'b1;
    s = cyc;
    chk(s + 1, F_SACT, 0, 1);
    chk(s + 1, F_SX, 0, 90);
    chk(s + 1, F_SY, 0, 420);
    chk(s + 2, F_SY, 0, 418);
    chk(s + 8, F_SACT, 0, 1);
    chk(s + 9, F_SACT, 0, 3);
    chk(s + 9, F_SY, 1, 420);
    chk(s + 9, F_SY, 0, 404);
    chk(s + 17, F_SACT, 0, 7);
    chk(s + 24, F_SACT, 0, 7);
    chk(s + 25, F_SACT, 0, 15);
    chk(s + 25, F_SY, 3, 420);
    chk(s + 33, F_SACT, 0, 15);
    chk(s + 40, F_SY, 0, 342);
    chk(s + 40, F_SY, 1, 358);
    run_to(s + 40);

    // shot_hit on slot 1: parks, and the freed slot is not reused in the same cycle
    bus.shot_hit = 4'b0010;
    chk(s + 41, F_SACT, 0, 13);
    chk(s + 41, F_SY, 1, 470);
    chk(s + 41, F_SX, 1, 0);
    tick(1);
    bus.shot_hit = 4'b0000;
    chk(s + 42, F_SACT, 0, 15);
    chk(s + 42, F_SY, 1, 420);
    chk(s + 42, F_SX, 1, 90);
    tick(1);
    bus.shoot = 1'b0;

    // Slot 0 reaches the top, retires, and is refilled one cycle later
    chk(s + 211, F_SY, 0, 0);
    chk(s + 211, F_SACT, 0, 15);
    run_to(s + 211);
    bus.shoot = 1'b1;
    chk(s + 212, F_SACT, 0, 14);
    chk(s + 212, F_SY, 0, 470);
    chk(s + 213, F_SACT, 0, 15);
    chk(s + 213, F_SY, 0, 420);
    chk(s + 213, F_SX, 0, 90);
    tick(2);
    bus.shoot = 1'b0;

    // Double hit on channels 2 and 5: one ack, one life, then invulnerability
    h = cyc;
    set_ep(2, 93, 410);
    set_ep(5, 93, 410);
    bus.eproj_valid = 11'h024;
    aq.push_back(11'h024);
    chk(h + 1, F_STATE, 0, 2);
    chk(h + 1, F_LIVES, 0, 4);
    chk(h + 1, F_INV, 0, 1);
    chk(h + 5, F_STATE, 0, 2);
    chk(h + 5, F_LIVES, 0, 4);
    chk(h + 32, F_STATE, 0, 2);
    chk(h + 33, F_STATE, 0, 1);
    chk(h + 33, F_INV, 0, 0);
    tick(5);
    bus.eproj_valid = '0;
    run_to(h + 34);

    // Four further separated hits drain the remaining lives
    for (int k = 1; k <= 4; k++) begin
      h = cyc;
      set_ep(0, 90, 410);
      bus.eproj_valid = 11'h001;
      aq.push_back(11'h001);
      chk(h + 1, F_LIVES, 0, 4 - k);
      if (k < 4) begin
        chk(h + 1, F_STATE, 0, 2);
      end else begin
        chk(h + 1, F_STATE, 0, 3);
        chk(h + 1, F_GO, 0, 1);
        chk(h + 1, F_SACT, 0, 0);
        chk(h + 1, F_SY, 0, 470);
        chk(h + 1, F_INV, 0, 0);
      end
      tick(1);
      bus.eproj_valid = '0;
      run_to(h + 34);
    end

    // OVER ignores fire and movement
    bus.shoot = 1'b1;
    bus.right = 1'b1;
    c = cyc;
    chk(c + 3, F_SACT, 0, 0);
    chk(c + 3, F_PX, 0, 90);
    chk(c + 3, F_STATE, 0, 3);
    tick(3);
    bus.shoot = 1'b0;
    bus.right = 1'b0;

    // play=0 returns to IDLE with fresh values
    bus.play = 1'b0;
    c = cyc;
    chk(c + 1, F_STATE, 0, 0);
    chk(c + 1, F_LIVES, 0, 5);
    chk(c + 1, F_GO, 0, 0);
    chk(c + 1, F_PX, 0, 320);
    tick(1);

    // New game, shoot, get hit, then async reset mid-HIT
    bus.play = 1'b1;
    c = cyc;
    tick(1);
    bus.shoot = 1'b1;
    tick(1);
    bus.shoot = 1'b0;
    set_ep(3, 323, 410);
    bus.eproj_valid = 11'h008;
    aq.push_back(11'h008);
    chk(c + 3, F_STATE, 0, 2);
    chk(c + 3, F_SACT, 0, 1);
    chk(c + 3, F_LIVES, 0, 4);
    tick(1);
    bus.eproj_valid = '0;
    tick(2);
    clr_n = 1'b0;
    c = cyc;
    chk(c, F_STATE, 0, 0);
    chk(c, F_SACT, 0, 0);
    chk(c, F_SY, 0, 470);
    chk(c, F_LIVES, 0, 5);
    chk(c, F_INV, 0, 0);
    chk(c, F_PX, 0, 320);
    tick(2);
    clr_n = 1'b1;
    bus.play = 1'b0;
    tick(3);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s[%0d] never sampled for cycle %0d required %0d",
               sel_name(e.sel), e.idx, e.cyc, e.val);
    end
    while (aq.size() > 0) begin
      logic [10:0] ea;
      ea = aq.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL hit_ack pulse missing: got none required %h", ea);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
